fft_frame_sequencer: RTL and testbench
======================================

Name: fft_frame_sequencer

Overview:
- Sits directly downstream of the debounced push-button pulse generators and upstream of the FFT core.
- Consumes single-cycle button pulses to capture N complex samples from board switches, one per press, into a frame register.
- Launches the FFT core with a one-cycle start strobe and latches the core's results.
- Steps through the latched results on a second button so they can be shown one bin at a time.

Parameters:
- N_POINTS, 4, number of samples per frame (power of two, ≥2).
- DATA_W, 8, bits per complex sample: upper DATA_W/2 = real, lower DATA_W/2 = imag, two's complement.
- IDX_W, 2, width of sample/bin index, = log2(N_POINTS).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- load_pulse  in  1  one-cycle pulse from debounced "load" button.
- next_pulse  in  1  one-cycle pulse from debounced "next" button.
- data_in  in  DATA_W  switch value sampled on load_pulse.
- fft_done  in  1  one-cycle completion strobe from FFT core.
- fft_result  in  N_POINTS*DATA_W  core outputs; bin k at bits [k*DATA_W +: DATA_W].
- frame_out  out  N_POINTS*DATA_W  captured samples to core; sample k at bits [k*DATA_W +: DATA_W].
- fft_start  out  1  one-cycle launch strobe to core.
- busy  out  1  high in START and WAIT.
- result_valid  out  1  high in SHOW.
- bin_idx  out  IDX_W  index of the bin currently on data_out.
- data_out  out  DATA_W  selected result bin (0 unless in SHOW).
- state_out  out  3  current state encoding for status LEDs.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high; all state updates on posedge clk.
- Reset values: state=IDLE, load_idx=0, bin_idx=0, frame_out=0, result register=0.
- Reset outputs: fft_start=0, busy=0, result_valid=0, data_out=0.
- Reset applied in any state, including mid-load or during WAIT, discards everything. A fft_done arriving in the same cycle as rst is lost.
- State encodings: IDLE=0, LOAD=1, START=2, WAIT=3, SHOW=4.
- IDLE:
  - load_pulse → frame_out slot 0 <= data_in, load_idx <= 1, go to LOAD.
  - next_pulse is ignored.
- LOAD:
  - load_pulse → slot[load_idx] <= data_in.
  - If load_idx==N_POINTS-1 at that press, go to START and set load_idx <= 0; otherwise load_idx++.
  - next_pulse is ignored. There is no timeout.
- START:
  - fft_start=1 for exactly this one cycle (registered output, asserted the cycle after the last capture).
  - Unconditionally go to WAIT.
- WAIT:
  - On fft_done, latch fft_result into the result register, bin_idx <= 0, go to SHOW.
  - Both button pulses are ignored.
  - frame_out holds stable throughout START and WAIT.
- SHOW:
  - data_out = result[bin_idx], registered, valid the same cycle result_valid is high.
  - next_pulse → bin_idx <= bin_idx+1, wrapping N_POINTS-1 → 0.
  - load_pulse → begin a new frame: slot 0 <= data_in, load_idx <= 1, go to LOAD. The result register is retained but result_valid drops and data_out returns to 0.
  - If load_pulse and next_pulse arrive in the same cycle, load wins and bin_idx is unchanged.
- fft_done outside WAIT is ignored and leaves the result register untouched.
- frame_out updates only on captures. Slots not yet overwritten in a new frame keep their previous frame's values.
- No arithmetic beyond index increment; indices wrap modulo N_POINTS with no saturation.

Test Plan:
- Reset then 4 load_pulses with data_in=0x11,0x22,0x33,0x44 → frame_out=0x44332211; fft_start high exactly one cycle, the cycle after the 4th capture; busy=1.
- In WAIT, assert fft_done with fft_result=0xA0B0C0D0 → next cycle result_valid=1, bin_idx=0, data_out=0xD0; 3 next_pulses → data_out 0xC0, 0xB0, 0xA0; a 4th → bin_idx=0, data_out=0xD0.
- next_pulse in IDLE and LOAD, and load_pulse/next_pulse during WAIT → no state or register change; fft_done pulsed in IDLE → result register still 0.
- In SHOW with bin_idx=2, assert load_pulse and next_pulse in the same cycle, data_in=0x55 → state=LOAD, slot0=0x55, load_idx=1, bin_idx stays 2, data_out=0.
- Assert rst after 2 captures and again during WAIT → next cycle all outputs at reset values, state_out=0; a subsequent full 4-sample frame behaves as in the first scenario.
- Back-to-back load_pulses on consecutive cycles → each captured into successive slots, no press lost.

Source files
------------

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: captures a frame from switches one press at a time,
// launches the FFT core, latches its results and steps through the bins.
module fft_frame_sequencer #(
    parameter int N_POINTS = 4,
    parameter int DATA_W   = 8,
    parameter int IDX_W    = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load_pulse,
    input  logic                         next_pulse,
    input  logic [DATA_W-1:0]            data_in,
    input  logic                         fft_done,
    input  logic [N_POINTS*DATA_W-1:0]   fft_result,
    output logic [N_POINTS*DATA_W-1:0]   frame_out,
    output logic                         fft_start,
    output logic                         busy,
    output logic                         result_valid,
    output logic [IDX_W-1:0]             bin_idx,
    output logic [DATA_W-1:0]            data_out,
    output logic [2:0]                   state_out
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_SHOW  = 3'd4
    } state_t;

    state_t                       state_q, state_d;
    logic [IDX_W-1:0]             load_idx_q, load_idx_d;
    logic [IDX_W-1:0]             bin_idx_q, bin_idx_d;
    logic [N_POINTS*DATA_W-1:0]   frame_q, frame_d;
    logic [N_POINTS*DATA_W-1:0]   result_q, result_d;
    logic                         fft_start_q, fft_start_d;
    logic [DATA_W-1:0]            data_out_q, data_out_d;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            load_idx_q  <= '0;
            bin_idx_q   <= '0;
            frame_q     <= '0;
            result_q    <= '0;
            fft_start_q <= 1'b0;
            data_out_q  <= '0;
        end else begin
            state_q     <= state_d;
            load_idx_q  <= load_idx_d;
            bin_idx_q   <= bin_idx_d;
            frame_q     <= frame_d;
            result_q    <= result_d;
            fft_start_q <= fft_start_d;
            data_out_q  <= data_out_d;
        end
    end

    // Next-state logic; registered outputs are derived from next-state values.
    always_comb begin
        state_d     = state_q;
        load_idx_d  = load_idx_q;
        bin_idx_d   = bin_idx_q;
        frame_d     = frame_q;
        result_d    = result_q;
        fft_start_d = 1'b0;
        data_out_d  = '0;

        unique case (state_q)
            S_IDLE: begin
                if (load_pulse) begin
                    frame_d[0 +: DATA_W] = data_in;
                    load_idx_d = IDX_W'(1);
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                if (load_pulse) begin
                    for (int k = 0; k < N_POINTS; k++) begin
                        if (load_idx_q == IDX_W'(k))
                            frame_d[k*DATA_W +: DATA_W] = data_in;
                    end
                    if (load_idx_q == IDX_W'(N_POINTS-1)) begin
                        load_idx_d = '0;
                        state_d    = S_START;
                    end else begin
                        load_idx_d = load_idx_q + IDX_W'(1);
                    end
                end
            end
            S_START: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (fft_done) begin
                    result_d  = fft_result;
                    bin_idx_d = '0;
                    state_d   = S_SHOW;
                end
            end
            S_SHOW: begin
                if (load_pulse) begin
                    frame_d[0 +: DATA_W] = data_in;
                    load_idx_d = IDX_W'(1);
                    state_d    = S_LOAD;
                end else if (next_pulse) begin
                    bin_idx_d = bin_idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        fft_start_d = (state_d == S_START);
        if (state_d == S_SHOW) begin
            for (int k = 0; k < N_POINTS; k++) begin
                if (bin_idx_d == IDX_W'(k))
                    data_out_d = result_d[k*DATA_W +: DATA_W];
            end
        end
    end

    assign frame_out    = frame_q;
    assign fft_start    = fft_start_q;
    assign busy         = (state_q == S_START) || (state_q == S_WAIT);
    assign result_valid = (state_q == S_SHOW);
    assign bin_idx      = bin_idx_q;
    assign data_out     = data_out_q;
    assign state_out    = state_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed testbench for fft_frame_sequencer: one task per scenario,
// expected values hand-computed from the behaviour description.
module tb_fft_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_pulse;
    logic        next_pulse;
    logic [7:0]  data_in;
    logic        fft_done;
    logic [31:0] fft_result;
    logic [31:0] frame_out;
    logic        fft_start;
    logic        busy;
    logic        result_valid;
    logic [1:0]  bin_idx;
    logic [7:0]  data_out;
    logic [2:0]  state_out;

    int n_cmp = 0;
    int n_err = 0;

    fft_frame_sequencer #(.N_POINTS(4), .DATA_W(8), .IDX_W(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_pulse   (load_pulse),
        .next_pulse   (next_pulse),
        .data_in      (data_in),
        .fft_done     (fft_done),
        .fft_result   (fft_result),
        .frame_out    (frame_out),
        .fft_start    (fft_start),
        .busy         (busy),
        .result_valid (result_valid),
        .bin_idx      (bin_idx),
        .data_out     (data_out),
        .state_out    (state_out)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic press_load(input logic [7:0] d);
        load_pulse = 1'b1;
        data_in    = d;
        cyc();
        load_pulse = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n_cmp++;
        if (state_out !== 3'd0) begin
            n_err++; $display("FAIL reset_state got=%0h exp=0", state_out);
        end
        n_cmp++;
        if (frame_out !== 32'h0) begin
            n_err++; $display("FAIL reset_frame got=%h exp=0", frame_out);
        end
        n_cmp++;
        if ({fft_start, busy, result_valid} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_flags got=%b exp=000",
                     {fft_start, busy, result_valid});
        end
        n_cmp++;
        if ({bin_idx, data_out} !== 10'h0) begin
            n_err++;
            $display("FAIL reset_bin_data got=%0h/%0h exp=0/0",
                     bin_idx, data_out);
        end
    endtask

    task automatic test_idle_ignore();
        next_pulse = 1'b1;
        fft_done   = 1'b1;
        fft_result = 32'hDEADBEEF;
        cyc();
        next_pulse = 1'b0;
        fft_done   = 1'b0;
        fft_result = 32'h0;
        n_cmp++;
        if ({state_out, result_valid, data_out} !== 12'h0) begin
            n_err++;
            $display("FAIL idle_ignore got st=%0h rv=%b d=%h exp=0/0/0",
                     state_out, result_valid, data_out);
        end
    endtask

    task automatic test_load_frame();
        press_load(8'h11);
        n_cmp++;
        if (state_out !== 3'd1 || frame_out !== 32'h00000011) begin
            n_err++;
            $display("FAIL load1 got st=%0h f=%h exp=1/00000011",
                     state_out, frame_out);
        end
        cyc();
        next_pulse = 1'b1;
        cyc();
        next_pulse = 1'b0;
        n_cmp++;
        if (state_out !== 3'd1 || frame_out !== 32'h00000011) begin
            n_err++;
            $display("FAIL load_next_ignored got st=%0h f=%h exp=1/00000011",
                     state_out, frame_out);
        end
        press_load(8'h22);
        cyc();
        press_load(8'h33);
        n_cmp++;
        if (fft_start !== 1'b0 || frame_out !== 32'h00332211) begin
            n_err++;
            $display("FAIL load3 got s=%b f=%h exp=0/00332211",
                     fft_start, frame_out);
        end
        press_load(8'h44);
        n_cmp++;
        if (frame_out !== 32'h44332211) begin
            n_err++; $display("FAIL load4_frame got=%h exp=44332211", frame_out);
        end
        n_cmp++;
        if ({state_out, fft_start, busy} !== 5'b010_1_1) begin
            n_err++;
            $display("FAIL start_cycle got st=%0h s=%b b=%b exp=2/1/1",
                     state_out, fft_start, busy);
        end
        cyc();
        n_cmp++;
        if ({state_out, fft_start, busy} !== 5'b011_0_1) begin
            n_err++;
            $display("FAIL wait_entry got st=%0h s=%b b=%b exp=3/0/1",
                     state_out, fft_start, busy);
        end
    endtask

    task automatic test_wait_ignore();
        load_pulse = 1'b1;
        next_pulse = 1'b1;
        data_in    = 8'h99;
        cyc();
        load_pulse = 1'b0;
        next_pulse = 1'b0;
        cyc();
        n_cmp++;
        if (state_out !== 3'd3 || frame_out !== 32'h44332211 ||
            busy !== 1'b1 || fft_start !== 1'b0) begin
            n_err++;
            $display("FAIL wait_ignore got st=%0h f=%h b=%b s=%b exp=3/44332211/1/0",
                     state_out, frame_out, busy, fft_start);
        end
    endtask

    task automatic test_show();
        logic [7:0] exp_d [5];
        logic [1:0] exp_b [5];
        exp_d = '{8'hD0, 8'hC0, 8'hB0, 8'hA0, 8'hD0};
        exp_b = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        fft_done   = 1'b1;
        fft_result = 32'hA0B0C0D0;
        cyc();
        fft_done   = 1'b0;
        fft_result = 32'h0;
        n_cmp++;
        if (state_out !== 3'd4 || result_valid !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL show_entry got st=%0h rv=%b b=%b exp=4/1/0",
                     state_out, result_valid, busy);
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                next_pulse = 1'b1;
                cyc();
                next_pulse = 1'b0;
            end
            n_cmp++;
            if (bin_idx !== exp_b[i] || data_out !== exp_d[i]) begin
                n_err++;
                $display("FAIL show_bin%0d got b=%0d d=%h exp=%0d/%h",
                         i, bin_idx, data_out, exp_b[i], exp_d[i]);
            end
        end
        next_pulse = 1'b1;
        cyc();
        cyc();
        next_pulse = 1'b0;
        fft_done   = 1'b1;
        fft_result = 32'h12345678;
        cyc();
        fft_done   = 1'b0;
        n_cmp++;
        if (bin_idx !== 2'd2 || data_out !== 8'hB0 || state_out !== 3'd4) begin
            n_err++;
            $display("FAIL show_done_ignored got b=%0d d=%h st=%0h exp=2/b0/4",
                     bin_idx, data_out, state_out);
        end
    endtask

    task automatic test_load_next_same();
        load_pulse = 1'b1;
        next_pulse = 1'b1;
        data_in    = 8'h55;
        cyc();
        load_pulse = 1'b0;
        next_pulse = 1'b0;
        n_cmp++;
        if (state_out !== 3'd1 || frame_out !== 32'h44332255) begin
            n_err++;
            $display("FAIL collide_load got st=%0h f=%h exp=1/44332255",
                     state_out, frame_out);
        end
        n_cmp++;
        if (bin_idx !== 2'd2 || data_out !== 8'h00 || result_valid !== 1'b0) begin
            n_err++;
            $display("FAIL collide_show got b=%0d d=%h rv=%b exp=2/00/0",
                     bin_idx, data_out, result_valid);
        end
        press_load(8'h66);
        n_cmp++;
        if (frame_out !== 32'h44336655) begin
            n_err++; $display("FAIL collide_idx1 got=%h exp=44336655", frame_out);
        end
        press_load(8'h77);
        press_load(8'h88);
        n_cmp++;
        if (frame_out !== 32'h88776655 || fft_start !== 1'b1) begin
            n_err++;
            $display("FAIL collide_frame got f=%h s=%b exp=88776655/1",
                     frame_out, fft_start);
        end
    endtask

    task automatic test_reset_midload();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        press_load(8'h01);
        press_load(8'h02);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n_cmp++;
        if (state_out !== 3'd0 || frame_out !== 32'h0 ||
            {fft_start, busy, result_valid} !== 3'b000 || data_out !== 8'h0) begin
            n_err++;
            $display("FAIL rst_midload got st=%0h f=%h fl=%b d=%h exp=0/0/000/0",
                     state_out, frame_out, {fft_start, busy, result_valid},
                     data_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_f [4];
        exp_f = '{32'h00000011, 32'h00002211, 32'h00332211, 32'h44332211};
        load_pulse = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_in = 8'h11 * 8'(i + 1);
            cyc();
            n_cmp++;
            if (frame_out !== exp_f[i]) begin
                n_err++;
                $display("FAIL b2b_slot%0d got=%h exp=%h", i, frame_out, exp_f[i]);
            end
        end
        load_pulse = 1'b0;
        n_cmp++;
        if (state_out !== 3'd2 || fft_start !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_start got st=%0h s=%b exp=2/1",
                     state_out, fft_start);
        end
        cyc();
        n_cmp++;
        if (fft_start !== 1'b0 || state_out !== 3'd3) begin
            n_err++;
            $display("FAIL b2b_start_once got s=%b st=%0h exp=0/3",
                     fft_start, state_out);
        end
    endtask

    task automatic test_reset_wait();
        rst        = 1'b1;
        fft_done   = 1'b1;
        fft_result = 32'hFFFFFFFF;
        cyc();
        rst      = 1'b0;
        fft_done = 1'b0;
        n_cmp++;
        if (state_out !== 3'd0 || frame_out !== 32'h0 ||
            {fft_start, busy, result_valid} !== 3'b000 ||
            data_out !== 8'h0 || bin_idx !== 2'd0) begin
            n_err++;
            $display("FAIL rst_wait got st=%0h f=%h fl=%b d=%h b=%0d exp=0/0/000/0/0",
                     state_out, frame_out, {fft_start, busy, result_valid},
                     data_out, bin_idx);
        end
        press_load(8'hA1);
        press_load(8'hB2);
        press_load(8'hC3);
        press_load(8'hD4);
        n_cmp++;
        if (frame_out !== 32'hD4C3B2A1 || fft_start !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL refill got f=%h s=%b b=%b exp=d4c3b2a1/1/1",
                     frame_out, fft_start, busy);
        end
        cyc();
        fft_done   = 1'b1;
        fft_result = 32'h01020304;
        cyc();
        fft_done = 1'b0;
        n_cmp++;
        if (result_valid !== 1'b1 || data_out !== 8'h04 || bin_idx !== 2'd0) begin
            n_err++;
            $display("FAIL refill_show got rv=%b d=%h b=%0d exp=1/04/0",
                     result_valid, data_out, bin_idx);
        end
    endtask

    initial begin
        rst        = 1'b1;
        load_pulse = 1'b0;
        next_pulse = 1'b0;
        data_in    = 8'h0;
        fft_done   = 1'b0;
        fft_result = 32'h0;
        cyc();
        test_reset();
        test_idle_ignore();
        test_load_frame();
        test_wait_ignore();
        test_show();
        test_load_next_same();
        test_reset_midload();
        test_back_to_back();
        test_reset_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
